// File: rtl/bdt_inference_scheduler.sv
// bdt_inference_scheduler: shares one ap_ctrl_hs BDT inference core between NUM_REQ requesters
// Ports: ap_clk / ap_rst_n (async active-low) clock and reset; req_valid / req_data / req_ready
// requester side with a one-hot accept strobe; core_ap_start / core_ap_ready / core_ap_done /
// core_features / core_score drive the core's ap_ctrl_hs interface; rsp_valid / rsp_ready /
// rsp_id / rsp_score / rsp_timeout carry the tagged response; busy, last_latency and done_count
// report status.
module bdt_inference_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int FEAT_W      = 160,
    parameter int SCORE_W     = 18,
    parameter int TIMEOUT_CYC = 1024,
    parameter int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*FEAT_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        core_ap_start,
    input  logic                        core_ap_ready,
    input  logic                        core_ap_done,
    output logic [FEAT_W-1:0]           core_features,
    input  logic [SCORE_W-1:0]          core_score,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [ID_W-1:0]             rsp_id,
    output logic [SCORE_W-1:0]          rsp_score,
    output logic                        rsp_timeout,
    output logic                        busy,
    output logic [15:0]                 last_latency,
    output logic [31:0]                 done_count
);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] START     = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;
    localparam logic [1:0] RESP      = 2'd3;

    logic [1:0]         rst_sync_q;
    logic               rst_n_int;
    logic [1:0]         state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d, id_q, id_d, grant;
    logic               grant_vld, done_ok;
    logic               start_q, start_d, to_q, to_d, rvalid_q, rvalid_d;
    logic [FEAT_W-1:0]  feat_q, feat_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [15:0]        timer_q, timer_d, lat_q, lat_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [ID_W:0]      j;

    // Reset asserts immediately but releases two clocks after ap_rst_n rises.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) rst_sync_q <= 2'b00;
        else           rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_int = rst_sync_q[1];

    // Walk the ring from the far end back to ptr so the nearest valid index wins.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        j         = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = {1'b0, ptr_q} + (ID_W + 1)'(k);
            if (j >= (ID_W + 1)'(NUM_REQ)) j = j - (ID_W + 1)'(NUM_REQ);
            if (req_valid[j[ID_W-1:0]]) begin
                grant_vld = 1'b1;
                grant     = j[ID_W-1:0];
            end
        end
    end

    // Accepts are withheld while the internal reset is still held after release.
    assign req_ready = (state_q == IDLE && grant_vld && rst_n_int) ? NUM_REQ'(1) << grant : '0;

    // A done seen in START only counts together with ready; stale pulses elsewhere are dropped.
    assign done_ok = (state_q == WAIT_DONE && core_ap_done) ||
                     (state_q == START && core_ap_ready && core_ap_done);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        start_d  = start_q;
        feat_d   = feat_q;
        id_d     = id_q;
        score_d  = score_q;
        to_d     = to_q;
        rvalid_d = rvalid_q;
        timer_d  = timer_q;
        lat_d    = lat_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    feat_d  = req_data[int'(grant)*FEAT_W +: FEAT_W];
                    id_d    = grant;
                    timer_d = '0;
                    start_d = 1'b1;
                    state_d = START;
                end
            end
            START, WAIT_DONE: begin
                timer_d = (&timer_q) ? timer_q : timer_q + 16'd1;
                if (done_ok) begin
                    start_d  = 1'b0;
                    score_d  = core_score;
                    to_d     = 1'b0;
                    lat_d    = timer_q;
                    cnt_d    = cnt_q + 32'd1;
                    rvalid_d = 1'b1;
                    state_d  = RESP;
                end else if (timer_q == 16'(TIMEOUT_CYC - 1)) begin
                    start_d  = 1'b0;
                    score_d  = '0;
                    to_d     = 1'b1;
                    rvalid_d = 1'b1;
                    state_d  = RESP;
                end else if (state_q == START && core_ap_ready) begin
                    start_d = 1'b0;
                    state_d = WAIT_DONE;
                end
            end
            default: begin
                if (rsp_ready) begin
                    rvalid_d = 1'b0;
                    ptr_d    = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
                    state_d  = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            start_q  <= 1'b0;
            feat_q   <= '0;
            id_q     <= '0;
            score_q  <= '0;
            to_q     <= 1'b0;
            rvalid_q <= 1'b0;
            timer_q  <= '0;
            lat_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            start_q  <= start_d;
            feat_q   <= feat_d;
            id_q     <= id_d;
            score_q  <= score_d;
            to_q     <= to_d;
            rvalid_q <= rvalid_d;
            timer_q  <= timer_d;
            lat_q    <= lat_d;
            cnt_q    <= cnt_d;
        end
    end

    assign core_ap_start = start_q;
    assign core_features = feat_q;
    assign rsp_valid     = rvalid_q;
    assign rsp_id        = id_q;
    assign rsp_score     = score_q;
    assign rsp_timeout   = to_q;
    assign busy          = (state_q != IDLE);
    assign last_latency  = lat_q;
    assign done_count    = cnt_q;
endmodule
